// File: rtl/ex_mem_branch_pipe_pkg.sv
// Shared types and constants for the EX->MEM branch-resolving pipeline register.
package rv_pipe_pkg;

  localparam int PC_STEP   = 4;
  localparam int PATTERN_W = 4;

  // Predictor training bundle: GHT direction update plus BTB target write
  typedef struct packed {
    logic                 ght_upd;
    logic [PATTERN_W-1:0] ght_pattern;
    logic                 ght_taken;
    logic                 btb_wr;
    logic [31:0]          btb_pc;
    logic [31:0]          btb_target;
  } branch_upd_t;

endpackage

// File: rtl/ex_mem_branch_pipe_if.sv
// Bundle of EX-stage inputs and MEM-stage / predictor-update outputs of the EX->MEM register.
interface ex_mem_branch_pipe_if #(parameter int CNT_W = 32);
  import rv_pipe_pkg::*;

  logic                 load;
  logic                 EX_valid;
  logic [31:0]          EX_pc;
  logic [31:0]          EX_alu_out;
  logic [31:0]          EX_rs2_out;
  logic                 EX_is_branch;
  logic                 EX_is_jump;
  logic                 EX_br_taken;
  logic [31:0]          EX_target;
  logic                 EX_BTB_hit;
  logic                 EX_prediction;
  logic [31:0]          EX_pred_target;
  logic [PATTERN_W-1:0] EX_pattern_used;

  logic                 MEM_valid;
  logic [31:0]          MEM_pc;
  logic [31:0]          MEM_alu_out;
  logic [31:0]          MEM_rs2_out;
  logic                 flush;
  logic [31:0]          redirect_pc;
  logic                 ght_upd;
  logic [PATTERN_W-1:0] ght_pattern;
  logic                 ght_taken;
  logic                 btb_wr;
  logic [31:0]          btb_pc;
  logic [31:0]          btb_target;
  logic [CNT_W-1:0]     br_count;
  logic [CNT_W-1:0]     mispred_count;

  modport master (
    output load, EX_valid, EX_pc, EX_alu_out, EX_rs2_out, EX_is_branch, EX_is_jump,
           EX_br_taken, EX_target, EX_BTB_hit, EX_prediction, EX_pred_target, EX_pattern_used,
    input  MEM_valid, MEM_pc, MEM_alu_out, MEM_rs2_out, flush, redirect_pc, ght_upd,
           ght_pattern, ght_taken, btb_wr, btb_pc, btb_target, br_count, mispred_count
  );

  modport slave (
    input  load, EX_valid, EX_pc, EX_alu_out, EX_rs2_out, EX_is_branch, EX_is_jump,
           EX_br_taken, EX_target, EX_BTB_hit, EX_prediction, EX_pred_target, EX_pattern_used,
    output MEM_valid, MEM_pc, MEM_alu_out, MEM_rs2_out, flush, redirect_pc, ght_upd,
           ght_pattern, ght_taken, btb_wr, btb_pc, btb_target, br_count, mispred_count
  );

endinterface

// File: rtl/ex_mem_branch_pipe_br_resolve.sv
// Combinational branch/jump resolution: mispredict detection, correct next PC and predictor training data.
module br_resolve
  import rv_pipe_pkg::*;
(
  input  logic                 is_branch_i,
  input  logic                 is_jump_i,
  input  logic                 br_taken_i,
  input  logic [31:0]          pc_i,
  input  logic [31:0]          target_i,
  input  logic                 btb_hit_i,
  input  logic                 prediction_i,
  input  logic [31:0]          pred_target_i,
  input  logic [PATTERN_W-1:0] pattern_i,
  output logic                 is_ctrl_o,
  output logic                 mispredict_o,
  output logic [31:0]          redirect_pc_o,
  output branch_upd_t          upd_o
);

  logic pred_taken;
  logic act_taken;

  // Compare fetch-time prediction against the real outcome; a jump always wins over a branch
  always_comb begin
    is_ctrl_o     = is_branch_i | is_jump_i;
    pred_taken    = btb_hit_i & prediction_i;
    act_taken     = is_jump_i | (is_branch_i & br_taken_i);
    mispredict_o  = (pred_taken != act_taken) | (act_taken & (pred_target_i != target_i));
    redirect_pc_o = act_taken ? target_i : pc_i + 32'(PC_STEP);

    upd_o             = '0;
    upd_o.ght_upd     = is_branch_i & ~is_jump_i;
    upd_o.ght_pattern = pattern_i;
    upd_o.ght_taken   = act_taken;
    upd_o.btb_wr      = act_taken & (~btb_hit_i | (pred_target_i != target_i));
    upd_o.btb_pc      = pc_i;
    upd_o.btb_target  = target_i;
  end

endmodule

// File: rtl/ex_mem_branch_pipe.sv
// EX->MEM pipeline register that resolves control flow, pulses flush/redirect and predictor writes,
// and keeps saturating branch and mispredict counters.
module ex_mem_branch_pipe
  import rv_pipe_pkg::*;
#(parameter int CNT_W = 32)
(
  input logic                 clk,
  input logic                 reset,
  ex_mem_branch_pipe_if.slave bus
);

  logic             mem_valid_q, mem_valid_d;
  logic [31:0]      mem_pc_q, mem_pc_d;
  logic [31:0]      mem_alu_q, mem_alu_d;
  logic [31:0]      mem_rs2_q, mem_rs2_d;
  logic             flush_q, flush_d;
  logic [31:0]      redirect_q, redirect_d;
  branch_upd_t      upd_q, upd_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;

  logic        is_ctrl;
  logic        mispredict;
  logic [31:0] redirect_pc;
  branch_upd_t upd;
  logic        resolve;

  br_resolve u_resolve (
    .is_branch_i   (bus.EX_is_branch),
    .is_jump_i     (bus.EX_is_jump),
    .br_taken_i    (bus.EX_br_taken),
    .pc_i          (bus.EX_pc),
    .target_i      (bus.EX_target),
    .btb_hit_i     (bus.EX_BTB_hit),
    .prediction_i  (bus.EX_prediction),
    .pred_target_i (bus.EX_pred_target),
    .pattern_i     (bus.EX_pattern_used),
    .is_ctrl_o     (is_ctrl),
    .mispredict_o  (mispredict),
    .redirect_pc_o (redirect_pc),
    .upd_o         (upd)
  );

  // An instruction arriving while flush is high is wrong-path and must not train or count
  assign resolve = bus.load & bus.EX_valid & ~flush_q & is_ctrl;

  // Next state: payload follows load, strobes self-clear, data fields hold until the next resolution
  always_comb begin
    mem_valid_d    = mem_valid_q;
    mem_pc_d       = mem_pc_q;
    mem_alu_d      = mem_alu_q;
    mem_rs2_d      = mem_rs2_q;
    flush_d        = 1'b0;
    redirect_d     = redirect_q;
    upd_d          = upd_q;
    upd_d.ght_upd  = 1'b0;
    upd_d.btb_wr   = 1'b0;
    br_cnt_d       = br_cnt_q;
    mis_cnt_d      = mis_cnt_q;

    if (bus.load) begin
      mem_valid_d = bus.EX_valid & ~flush_q;
      mem_pc_d    = bus.EX_pc;
      mem_alu_d   = bus.EX_alu_out;
      mem_rs2_d   = bus.EX_rs2_out;
    end

    if (resolve) begin
      flush_d    = mispredict;
      redirect_d = redirect_pc;
      upd_d      = upd;
      if (br_cnt_q != '1)
        br_cnt_d = br_cnt_q + CNT_W'(1);
      if (mispredict && (mis_cnt_q != '1))
        mis_cnt_d = mis_cnt_q + CNT_W'(1);
    end
  end

  // State registers with synchronous reset clearing every output
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_valid_q <= 1'b0;
      mem_pc_q    <= '0;
      mem_alu_q   <= '0;
      mem_rs2_q   <= '0;
      flush_q     <= 1'b0;
      redirect_q  <= '0;
      upd_q       <= '0;
      br_cnt_q    <= '0;
      mis_cnt_q   <= '0;
    end else begin
      mem_valid_q <= mem_valid_d;
      mem_pc_q    <= mem_pc_d;
      mem_alu_q   <= mem_alu_d;
      mem_rs2_q   <= mem_rs2_d;
      flush_q     <= flush_d;
      redirect_q  <= redirect_d;
      upd_q       <= upd_d;
      br_cnt_q    <= br_cnt_d;
      mis_cnt_q   <= mis_cnt_d;
    end
  end

  assign bus.MEM_valid     = mem_valid_q;
  assign bus.MEM_pc        = mem_pc_q;
  assign bus.MEM_alu_out   = mem_alu_q;
  assign bus.MEM_rs2_out   = mem_rs2_q;
  assign bus.flush         = flush_q;
  assign bus.redirect_pc   = redirect_q;
  assign bus.ght_upd       = upd_q.ght_upd;
  assign bus.ght_pattern   = upd_q.ght_pattern;
  assign bus.ght_taken     = upd_q.ght_taken;
  assign bus.btb_wr        = upd_q.btb_wr;
  assign bus.btb_pc        = upd_q.btb_pc;
  assign bus.btb_target    = upd_q.btb_target;
  assign bus.br_count      = br_cnt_q;
  assign bus.mispred_count = mis_cnt_q;

endmodule

// File: tb/tb_ex_mem_branch_pipe.sv
// Self-checking bench for ex_mem_branch_pipe: directed vector table, hand-written corner sequences,
// and randomized traffic against a behavioural model of the resolution rules.
module tb_ex_mem_branch_pipe;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic        load;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] rs2;
    logic        isb;
    logic        isj;
    logic        tk;
    logic [31:0] tgt;
    logic        hit;
    logic        pred;
    logic [31:0] ptgt;
    logic [3:0]  pat;
  } in_t;

  typedef struct packed {
    logic        mem_valid;
    logic [31:0] mem_pc;
    logic [31:0] mem_alu;
    logic [31:0] mem_rs2;
    logic        flush;
    logic [31:0] redirect;
    logic        ght_upd;
    logic [3:0]  ght_pattern;
    logic        ght_taken;
    logic        btb_wr;
    logic [31:0] btb_pc;
    logic [31:0] btb_target;
  } out_t;

  typedef struct packed {
    in_t         s;
    logic        mv;
    logic        fl;
    logic [31:0] rd;
    logic        gu;
    logic        gt;
    logic        bw;
    logic [3:0]  bc;
    logic [3:0]  mc;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  in_t  cur;
  out_t m;
  int   mBr;
  int   mMis;
  int   total = 0;
  int   bad = 0;
  vec_t vecs[11];

  ex_mem_branch_pipe_if #(.CNT_W(CNT_W)) bus ();

  ex_mem_branch_pipe #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic in_t mkIn(input logic ld, input logic v, input logic [31:0] pc,
                               input logic isb, input logic isj, input logic tk,
                               input logic [31:0] tgt, input logic hit, input logic pred,
                               input logic [31:0] ptgt);
    in_t s;
    s.load  = ld;
    s.valid = v;
    s.pc    = pc;
    s.alu   = pc ^ 32'h5A5A_0000;
    s.rs2   = pc + 32'h0000_1000;
    s.isb   = isb;
    s.isj   = isj;
    s.tk    = tk;
    s.tgt   = tgt;
    s.hit   = hit;
    s.pred  = pred;
    s.ptgt  = ptgt;
    s.pat   = pc[5:2];
    return s;
  endfunction

  task automatic applyStimulus(input in_t s);
    cur                 = s;
    bus.load            = s.load;
    bus.EX_valid        = s.valid;
    bus.EX_pc           = s.pc;
    bus.EX_alu_out      = s.alu;
    bus.EX_rs2_out      = s.rs2;
    bus.EX_is_branch    = s.isb;
    bus.EX_is_jump      = s.isj;
    bus.EX_br_taken     = s.tk;
    bus.EX_target       = s.tgt;
    bus.EX_BTB_hit      = s.hit;
    bus.EX_prediction   = s.pred;
    bus.EX_pred_target  = s.ptgt;
    bus.EX_pattern_used = s.pat;
  endtask

  // Reference behaviour written directly from the resolution rules
  task automatic modelStep(input logic rst, input in_t s);
    logic oldFlush;
    logic predTaken;
    logic actTaken;
    logic mp;
    if (rst) begin
      m    = '0;
      mBr  = 0;
      mMis = 0;
      return;
    end
    oldFlush  = m.flush;
    m.flush   = 1'b0;
    m.ght_upd = 1'b0;
    m.btb_wr  = 1'b0;
    if (!s.load) return;
    m.mem_valid = s.valid && !oldFlush;
    m.mem_pc    = s.pc;
    m.mem_alu   = s.alu;
    m.mem_rs2   = s.rs2;
    if (!(s.valid && !oldFlush && (s.isb || s.isj))) return;
    actTaken  = s.isj ? 1'b1 : s.tk;
    predTaken = s.hit && s.pred;
    mp        = (predTaken != actTaken) || (actTaken && (s.ptgt != s.tgt));
    m.flush       = mp;
    m.redirect    = actTaken ? s.tgt : s.pc + 32'd4;
    m.ght_upd     = s.isb && !s.isj;
    m.ght_pattern = s.pat;
    m.ght_taken   = actTaken;
    m.btb_wr      = actTaken && (!s.hit || (s.ptgt != s.tgt));
    m.btb_pc      = s.pc;
    m.btb_target  = s.tgt;
    if (mBr < CNT_MAX) mBr++;
    if (mp && mMis < CNT_MAX) mMis++;
  endtask

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s got=%h want=%h @%0t", name, got, want, $time);
    end
  endtask

  task automatic checkOutput(input string tag);
    cmp({tag, ".MEM_valid"},     32'(bus.MEM_valid),     32'(m.mem_valid));
    cmp({tag, ".MEM_pc"},        bus.MEM_pc,             m.mem_pc);
    cmp({tag, ".MEM_alu_out"},   bus.MEM_alu_out,        m.mem_alu);
    cmp({tag, ".MEM_rs2_out"},   bus.MEM_rs2_out,        m.mem_rs2);
    cmp({tag, ".flush"},         32'(bus.flush),         32'(m.flush));
    cmp({tag, ".redirect_pc"},   bus.redirect_pc,        m.redirect);
    cmp({tag, ".ght_upd"},       32'(bus.ght_upd),       32'(m.ght_upd));
    cmp({tag, ".ght_pattern"},   32'(bus.ght_pattern),   32'(m.ght_pattern));
    cmp({tag, ".ght_taken"},     32'(bus.ght_taken),     32'(m.ght_taken));
    cmp({tag, ".btb_wr"},        32'(bus.btb_wr),        32'(m.btb_wr));
    cmp({tag, ".btb_pc"},        bus.btb_pc,             m.btb_pc);
    cmp({tag, ".btb_target"},    bus.btb_target,         m.btb_target);
    cmp({tag, ".br_count"},      32'(bus.br_count),      32'(mBr));
    cmp({tag, ".mispred_count"}, 32'(bus.mispred_count), 32'(mMis));
  endtask

  // One clock: model consumes the inputs seen at the edge, outputs sampled 1 time unit later
  task automatic tick(input string tag);
    @(posedge clk);
    modelStep(reset, cur);
    #1;
    checkOutput(tag);
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus('0);
    repeat (3) tick("reset");
    reset = 1'b0;
  endtask

  function automatic in_t randIn();
    in_t s;
    int  k;
    s      = mkIn(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    s.load = ($urandom_range(0, 3) != 0);
    s.valid = ($urandom_range(0, 4) != 0);
    s.pc   = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
    s.alu  = $urandom();
    s.rs2  = $urandom();
    k      = int'($urandom_range(0, 3));
    s.isb  = (k == 1) || (k == 3);
    s.isj  = (k == 2) || (k == 3);
    s.tk   = 1'($urandom_range(0, 1));
    s.tgt  = 32'h1000 + 32'($urandom_range(0, 3)) * 32'd4;
    s.ptgt = 32'h1000 + 32'($urandom_range(0, 3)) * 32'd4;
    s.hit  = 1'($urandom_range(0, 1));
    s.pred = 1'($urandom_range(0, 1));
    s.pat  = 4'($urandom_range(0, 15));
    return s;
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    // Directed table: fields are stimulus, MEM_valid, flush, redirect, ght_upd, ght_taken, btb_wr, br, mispred
    vecs[0]  = '{mkIn(1, 1, 32'h100, 1, 0, 1, 32'h140, 0, 0, 32'h0),   1, 1, 32'h140, 1, 1, 1, 4'd1, 4'd1};
    vecs[1]  = '{mkIn(1, 1, 32'h144, 1, 0, 1, 32'h190, 0, 0, 32'h0),   0, 0, 32'h140, 0, 1, 0, 4'd1, 4'd1};
    vecs[2]  = '{mkIn(1, 1, 32'h200, 1, 0, 1, 32'h180, 1, 1, 32'h180), 1, 0, 32'h180, 1, 1, 0, 4'd2, 4'd1};
    vecs[3]  = '{mkIn(1, 1, 32'h300, 1, 0, 0, 32'h340, 1, 1, 32'h340), 1, 1, 32'h304, 1, 0, 0, 4'd3, 4'd2};
    vecs[4]  = '{mkIn(1, 1, 32'h304, 0, 0, 0, 32'h0, 0, 0, 32'h0),     0, 0, 32'h304, 0, 0, 0, 4'd3, 4'd2};
    vecs[5]  = '{mkIn(1, 1, 32'h400, 0, 0, 0, 32'h0, 0, 0, 32'h0),     1, 0, 32'h304, 0, 0, 0, 4'd3, 4'd2};
    vecs[6]  = '{mkIn(1, 1, 32'h500, 1, 1, 0, 32'h600, 1, 1, 32'h600), 1, 0, 32'h600, 0, 1, 0, 4'd4, 4'd2};
    vecs[7]  = '{mkIn(1, 0, 32'h700, 1, 0, 1, 32'h740, 0, 0, 32'h0),   0, 0, 32'h600, 0, 1, 0, 4'd4, 4'd2};
    vecs[8]  = '{mkIn(1, 1, 32'hFFFF_FFFC, 0, 1, 0, 32'h20, 1, 1, 32'h10), 1, 1, 32'h20, 0, 1, 1, 4'd5, 4'd3};
    vecs[9]  = '{mkIn(0, 1, 32'h900, 1, 0, 1, 32'h999, 0, 0, 32'h0),   1, 0, 32'h20, 0, 1, 0, 4'd5, 4'd3};
    vecs[10] = '{mkIn(1, 1, 32'hFFFF_FFFC, 1, 0, 0, 32'h80, 1, 1, 32'h80), 1, 1, 32'h0, 1, 0, 0, 4'd6, 4'd4};

    reset = 1'b1;
    applyStimulus('0);
    m    = '0;
    mBr  = 0;
    mMis = 0;

    // Reset state, then release with load low
    doReset();
    cmp("rst.flush", 32'(bus.flush), 32'd0);
    cmp("rst.redirect_pc", bus.redirect_pc, 32'd0);
    cmp("rst.br_count", 32'(bus.br_count), 32'd0);
    repeat (2) tick("idle");
    cmp("idle.MEM_valid", 32'(bus.MEM_valid), 32'd0);

    // Directed vector table
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].s);
      tick($sformatf("vec%0d", i));
      cmp($sformatf("vec%0d.MEM_valid", i), 32'(bus.MEM_valid), 32'(vecs[i].mv));
      cmp($sformatf("vec%0d.flush", i), 32'(bus.flush), 32'(vecs[i].fl));
      cmp($sformatf("vec%0d.redirect_pc", i), bus.redirect_pc, vecs[i].rd);
      cmp($sformatf("vec%0d.ght_upd", i), 32'(bus.ght_upd), 32'(vecs[i].gu));
      cmp($sformatf("vec%0d.ght_taken", i), 32'(bus.ght_taken), 32'(vecs[i].gt));
      cmp($sformatf("vec%0d.btb_wr", i), 32'(bus.btb_wr), 32'(vecs[i].bw));
      cmp($sformatf("vec%0d.br_count", i), 32'(bus.br_count), 32'(vecs[i].bc));
      cmp($sformatf("vec%0d.mispred_count", i), 32'(bus.mispred_count), 32'(vecs[i].mc));
    end

    // Jump mispredict followed by a three-cycle hold, then reset while flush is high
    doReset();
    applyStimulus(mkIn(1, 1, 32'h800, 0, 1, 0, 32'h840, 0, 0, 32'h0));
    tick("jmp");
    cmp("jmp.flush", 32'(bus.flush), 32'd1);
    cmp("jmp.redirect_pc", bus.redirect_pc, 32'h840);
    applyStimulus(mkIn(0, 1, 32'h900, 0, 1, 0, 32'h940, 0, 0, 32'h0));
    for (int i = 0; i < 3; i++) begin
      tick("hold");
      cmp("hold.flush", 32'(bus.flush), 32'd0);
      cmp("hold.MEM_pc", bus.MEM_pc, 32'h800);
      cmp("hold.MEM_valid", 32'(bus.MEM_valid), 32'd1);
    end
    applyStimulus(mkIn(1, 1, 32'hA00, 0, 1, 0, 32'hA40, 0, 0, 32'h0));
    tick("jmp2");
    cmp("jmp2.flush", 32'(bus.flush), 32'd1);
    reset = 1'b1;
    applyStimulus(mkIn(1, 1, 32'hB00, 1, 0, 1, 32'hB40, 0, 0, 32'h0));
    tick("midrst");
    cmp("midrst.flush", 32'(bus.flush), 32'd0);
    cmp("midrst.btb_wr", 32'(bus.btb_wr), 32'd0);
    cmp("midrst.mispred_count", 32'(bus.mispred_count), 32'd0);
    reset = 1'b0;
    applyStimulus('0);
    tick("postrst");

    // Saturation of both counters at all-ones
    doReset();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(mkIn(1, 1, 32'h1000 + 32'(i) * 32'd16, 1, 0, 1, 32'h2000, 0, 0, 32'h0));
      tick("sat");
      cmp("sat.flush", 32'(bus.flush), 32'd1);
      applyStimulus('0);
      tick("satgap");
    end
    cmp("sat.mispred_count", 32'(bus.mispred_count), 32'd15);
    cmp("sat.br_count", 32'(bus.br_count), 32'd15);

    // Randomized traffic with occasional resets
    doReset();
    for (int i = 0; i < 800; i++) begin
      reset = ($urandom_range(0, 49) == 0);
      applyStimulus(randIn());
      tick("rand");
    end
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
